// File: rtl/pwm_step_ctrl.sv
// Push-button duty-step controller: synchronizes debounced inc/dec presses, applies one
// saturating step per press, and drives a PWM output whose duty changes only at period wraps.
module pwm_step_ctrl #(
    parameter int PERIOD    = 100,
    parameter int STEP      = 10,
    parameter int DUTY_INIT = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_req,
    input  logic       dec_req,
    output logic       pwm_out,
    output logic [7:0] duty,
    output logic       at_max,
    output logic       at_min
);

    localparam logic [7:0] PERIOD_W = 8'(PERIOD);
    localparam logic [7:0] STEP_W   = 8'(STEP);
    localparam logic [7:0] INIT_W   = 8'(DUTY_INIT);
    localparam logic [7:0] LAST_CNT = 8'(PERIOD - 1);

    // bit 0 = s0, bit 1 = s1 (synchronized), bit 2 = s2 (history)
    logic [2:0] inc_sync;
    logic [2:0] dec_sync;
    logic       inc_ev;
    logic       dec_ev;

    logic [7:0] cnt;
    logic [7:0] duty_act;
    logic [7:0] duty_next;
    logic [8:0] duty_sum;
    logic       wrap;

    // NOTE: every sequential process uses non-blocking assignments so all flops
    // sample pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_sync <= '0;
            dec_sync <= '0;
        end else begin
            inc_sync <= {inc_sync[1:0], inc_req};
            dec_sync <= {dec_sync[1:0], dec_req};
        end
    end

    assign inc_ev = inc_sync[1] & ~inc_sync[2];
    assign dec_ev = dec_sync[1] & ~dec_sync[2];

    // NOTE: duty_next is defaulted before any branch so no latch is inferred.
    always_comb begin
        duty_next = duty;
        duty_sum  = {1'b0, duty} + {1'b0, STEP_W};
        if (inc_ev && !dec_ev) begin
            duty_next = (duty_sum > {1'b0, PERIOD_W}) ? PERIOD_W : duty_sum[7:0];
        end else if (dec_ev && !inc_ev) begin
            duty_next = (duty < STEP_W) ? 8'd0 : duty - STEP_W;
        end
    end

    assign wrap = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            duty     <= INIT_W;
            cnt      <= '0;
            duty_act <= INIT_W;
            pwm_out  <= 1'b0;
        end else begin
            duty    <= duty_next;
            cnt     <= wrap ? 8'd0 : cnt + 8'd1;
            pwm_out <= (cnt < duty_act);
            // Shadow takes the pre-update duty when a step lands on the wrap edge.
            if (wrap) begin
                duty_act <= duty;
            end
        end
    end

    assign at_max = (duty == PERIOD_W);
    assign at_min = (duty == 8'd0);

endmodule
